minialu_core_gen2: RTL and testbench

- Parametrised second-generation MiniALU execution core: 2-stage pipeline (fetch, execute) with internal register file, full one-cycle result forwarding, nested CALL/RET via a LIFO return stack, and LED and video-memory write outputs.
- Instruction ROM and video RAM are external. The core drives the fetch address and consumes one instruction word per cycle.
- The top level replaces the previous core with this block and connects the ROM, VGA memory and LEDs to its ports.

---
 rtl/minialu_pkg.sv | 48 ++++
 rtl/minialu_core_gen2_if.sv | 26 ++
 rtl/minialu_call_stack.sv | 44 ++++
 rtl/minialu_core_gen2.sv | 166 ++++++++++++++++
 tb/tb_minialu_core_gen2.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/minialu_pkg.sv
// rtl/minialu_pkg.sv - MiniALU opcodes, instruction field offsets and write decode (MINIALU_MUL_EN makes op 14 a MUL)
package minialu_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_BLE  = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_CALL = 4'd9;
  localparam logic [3:0] OP_RET  = 4'd10;
  localparam logic [3:0] OP_LED  = 4'd11;
  localparam logic [3:0] OP_STO  = 4'd12;
  localparam logic [3:0] OP_WVM  = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;
  localparam logic [3:0] OP_NOP2 = 4'd15;

  // Instruction word is {op, dest, src1, src0}; src0 always starts at bit 0.
  localparam int SRC0_LSB = 0;

  function automatic int src1_lsb(input int addrW);
    return addrW;
  endfunction

  function automatic int dest_lsb(input int addrW);
    return 2 * addrW;
  endfunction

  function automatic int op_lsb(input int addrW);
    return 3 * addrW;
  endfunction

  function automatic logic is_reg_write(input logic [3:0] op);
    logic we;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_STO: we = 1'b1;
`ifdef MINIALU_MUL_EN
      OP_MUL: we = 1'b1;
`endif
      default: we = 1'b0;
    endcase
    return we;
  endfunction

endpackage

// File: rtl/minialu_core_gen2_if.sv
// rtl/minialu_core_gen2_if.sv - fetch, LED and video-write signal bundle of the MiniALU core
interface minialu_core_gen2_if #(
  parameter int ADDR_W  = 8,
  parameter int IP_W    = 16,
  parameter int LED_W   = 8,
  parameter int VADDR_W = 10,
  parameter int COLOR_W = 3
);
  logic [IP_W-1:0]       oIP;
  logic [4+3*ADDR_W-1:0] iInstruction;
  logic [LED_W-1:0]      oLed;
  logic                  oVideoWe;
  logic [VADDR_W-1:0]    oVideoAddr;
  logic [COLOR_W-1:0]    oVideoData;
  logic                  oStackErr;

  modport master (
    output oIP, oLed, oVideoWe, oVideoAddr, oVideoData, oStackErr,
    input  iInstruction
  );

  modport slave (
    input  oIP, oLed, oVideoWe, oVideoAddr, oVideoData, oStackErr,
    output iInstruction
  );
endinterface

// File: rtl/minialu_call_stack.sv
// rtl/minialu_call_stack.sv - LIFO of return addresses for CALL/RET
module minialu_call_stack #(
  parameter int IP_W        = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            push,
  input  logic            pop,
  input  logic [IP_W-1:0] din,
  output logic [IP_W-1:0] dout,
  output logic            full,
  output logic            empty
);
  localparam int PTR_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PTR_W-1:0] sp;
  logic [PTR_W-1:0] spDec;
  logic [IP_W-1:0]  entries [2**IDX_W];

  assign spDec = sp - PTR_W'(1);
  assign full  = (sp == PTR_W'(STACK_DEPTH));
  assign empty = (sp == '0);
  assign dout  = entries[IDX_W'(spDec)];

  // Stack pointer: one push or one pop per cycle, never past the ends
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + PTR_W'(1);
    end else if (pop && !empty) begin
      sp <= spDec;
    end
  end

  // Entry storage: written at the current pointer on push
  always_ff @(posedge Clock) begin
    if (push && !full) begin
      entries[IDX_W'(sp)] <= din;
    end
  end
endmodule

// File: rtl/minialu_core_gen2.sv
// rtl/minialu_core_gen2.sv - 2-stage MiniALU core with forwarding and return stack (MINIALU_MUL_EN adds MUL)
module minialu_core_gen2
  import minialu_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int IP_W        = 16,
  parameter int STACK_DEPTH = 4,
  parameter int LED_W       = 8,
  parameter int VADDR_W     = 10,
  parameter int COLOR_W     = 3
) (
  input logic Clock,
  input logic Reset,
  minialu_core_gen2_if.master bus
);
  localparam int INSTR_W = 4 + 3 * ADDR_W;
  localparam int S1_LSB  = src1_lsb(ADDR_W);
  localparam int D_LSB   = dest_lsb(ADDR_W);
  localparam int OP_LSB  = op_lsb(ADDR_W);

  logic [INSTR_W-1:0]  exInstr;
  logic [IP_W-1:0]     ipCnt, exIp, fetchIp, branchTarget, stackTop, retAddr;
  logic [DATA_W-1:0]   regFile [2**ADDR_W];
  logic [DATA_W-1:0]   rdData0, rdData1, src0Val, src1Val, result;
  logic                fwdValid;
  logic [ADDR_W-1:0]   fwdAddr;
  logic [DATA_W-1:0]   fwdData;
  logic [3:0]          exOp;
  logic [ADDR_W-1:0]   exDest, exSrc0, exSrc1, inSrc0, inSrc1;
  logic [2*ADDR_W-1:0] stoImm;
  logic                regWe, branchTaken, stackPush, stackPop, stackFault;
  logic                stackFull, stackEmpty;
  logic [LED_W-1:0]    ledReg;
  logic                videoWe;
  logic [VADDR_W-1:0]  videoAddr;
  logic [COLOR_W-1:0]  videoData;
  logic                stackErr;

  assign exOp    = exInstr[OP_LSB +: 4];
  assign exDest  = exInstr[D_LSB +: ADDR_W];
  assign exSrc1  = exInstr[S1_LSB +: ADDR_W];
  assign exSrc0  = exInstr[SRC0_LSB +: ADDR_W];
  assign inSrc1  = bus.iInstruction[S1_LSB +: ADDR_W];
  assign inSrc0  = bus.iInstruction[SRC0_LSB +: ADDR_W];
  assign stoImm  = {exSrc1, exSrc0};
  assign regWe   = is_reg_write(exOp);
  assign retAddr = exIp + IP_W'(1);

  // Operand selection (last cycle's result beats the RAM read) and ALU
  always_comb begin
    src0Val = (fwdValid && fwdAddr == exSrc0) ? fwdData : rdData0;
    src1Val = (fwdValid && fwdAddr == exSrc1) ? fwdData : rdData1;
    result  = '0;
    case (exOp)
      OP_ADD: result = src1Val + src0Val;
      OP_SUB: result = src1Val - src0Val;
      OP_AND: result = src1Val & src0Val;
      OP_OR:  result = src1Val | src0Val;
      OP_SHL: result = src1Val << src0Val[3:0];
      OP_SHR: result = src1Val >> src0Val[3:0];
      OP_STO: result = DATA_W'(stoImm);
`ifdef MINIALU_MUL_EN
      OP_MUL: result = src1Val * src0Val;
`endif
      default: result = '0;
    endcase
  end

  // Branch decision and return-stack control; a blocked CALL/RET falls through
  always_comb begin
    branchTaken  = 1'b0;
    branchTarget = IP_W'(exDest);
    stackPush    = 1'b0;
    stackPop     = 1'b0;
    stackFault   = 1'b0;
    case (exOp)
      OP_BLE: branchTaken = (src1Val <= src0Val);
      OP_JMP: branchTaken = 1'b1;
      OP_CALL: begin
        if (stackFull) begin
          stackFault = 1'b1;
        end else begin
          stackPush   = 1'b1;
          branchTaken = 1'b1;
        end
      end
      OP_RET: begin
        if (stackEmpty) begin
          stackFault = 1'b1;
        end else begin
          stackPop     = 1'b1;
          branchTaken  = 1'b1;
          branchTarget = stackTop;
        end
      end
      default: ;
    endcase
  end

  assign fetchIp        = branchTaken ? branchTarget : ipCnt;
  assign bus.oIP        = fetchIp;
  assign bus.oLed       = ledReg;
  assign bus.oVideoWe   = videoWe;
  assign bus.oVideoAddr = videoAddr;
  assign bus.oVideoData = videoData;
  assign bus.oStackErr  = stackErr;

  minialu_call_stack #(
    .IP_W        (IP_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) uStack (
    .Clock (Clock),
    .Reset (Reset),
    .push  (stackPush),
    .pop   (stackPop),
    .din   (retAddr),
    .dout  (stackTop),
    .full  (stackFull),
    .empty (stackEmpty)
  );

  // Pipeline registers, IP counter, forwarding latch and output registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      exInstr   <= '0;
      exIp      <= '0;
      ipCnt     <= '0;
      fwdValid  <= 1'b0;
      fwdAddr   <= '0;
      fwdData   <= '0;
      ledReg    <= '0;
      videoWe   <= 1'b0;
      videoAddr <= '0;
      videoData <= '0;
      stackErr  <= 1'b0;
    end else begin
      exInstr  <= bus.iInstruction;
      exIp     <= fetchIp;
      ipCnt    <= fetchIp + IP_W'(1);
      fwdValid <= regWe;
      fwdAddr  <= exDest;
      fwdData  <= result;
      videoWe  <= (exOp == OP_WVM);
      if (exOp == OP_LED) begin
        ledReg <= src1Val[LED_W-1:0];
      end
      if (exOp == OP_WVM) begin
        videoAddr <= src0Val[VADDR_W-1:0];
        videoData <= src1Val[COLOR_W-1:0];
      end
      if (stackFault) begin
        stackErr <= 1'b1;
      end
    end
  end

  // Register file: write the execute result, read the newly fetched sources
  always_ff @(posedge Clock) begin
    if (regWe) begin
      regFile[exDest] <= result;
    end
    rdData0 <= regFile[inSrc0];
    rdData1 <= regFile[inSrc1];
  end
endmodule

// File: tb/tb_minialu_core_gen2.sv
// tb/tb_minialu_core_gen2.sv - scoreboard bench for minialu_core_gen2
module tb_minialu_core_gen2;
  import minialu_pkg::*;

  typedef struct packed {
    logic [15:0] ip;
    logic        err;
  } trace_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  minialu_core_gen2_if #(.ADDR_W(8), .IP_W(16), .LED_W(8), .VADDR_W(10), .COLOR_W(3)) bus ();

  minialu_core_gen2 #(
    .DATA_W(16), .ADDR_W(8), .IP_W(16), .STACK_DEPTH(4),
    .LED_W(8), .VADDR_W(10), .COLOR_W(3)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.master)
  );

  logic [27:0] rom [256];
  assign bus.iInstruction = (bus.oIP < 16'd256) ? rom[bus.oIP[7:0]] : 28'd0;

  trace_t      ipQ[$];
  logic [7:0]  ledQ[$];
  logic [12:0] vidQ[$];
  int checks   = 0;
  int failures = 0;
  logic [7:0] lastLed = 8'd0;

  function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  function automatic logic [27:0] sto(input logic [7:0] d, input logic [15:0] v);
    return {OP_STO, d, v};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a fetch, LED change or video write
  always @(negedge Clock) begin
    trace_t t;
    if (!Reset) begin
      if (ipQ.size() > 0) begin
        t = ipQ.pop_front();
        check("oIP", {16'd0, bus.oIP}, {16'd0, t.ip});
        check("oStackErr", {31'd0, bus.oStackErr}, {31'd0, t.err});
      end
      if (bus.oLed != lastLed) begin
        if (ledQ.size() == 0) check("unexpected_led", {24'd0, bus.oLed}, {24'd0, lastLed});
        else check("oLed", {24'd0, bus.oLed}, {24'd0, ledQ.pop_front()});
      end
      if (bus.oVideoWe) begin
        if (vidQ.size() == 0) check("unexpected_video_we", 32'd1, 32'd0);
        else check("video", {19'd0, bus.oVideoAddr, bus.oVideoData}, {19'd0, vidQ.pop_front()});
      end
    end
    lastLed = bus.oLed;
  end

  task automatic holdReset();
    @(posedge Clock);
    #2;
    Reset = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 28'd0;
    @(posedge Clock);
    #1;
  endtask

  task automatic pushSeq(input int first, input int last, input logic err);
    for (int i = first; i <= last; i++) ipQ.push_back('{ip: 16'(i), err: err});
  endtask

  task automatic pushIp(input int ip, input logic err);
    ipQ.push_back('{ip: 16'(ip), err: err});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && (ipQ.size() + ledQ.size() + vidQ.size()) > 0; i++) @(posedge Clock);
    check(name, ipQ.size() + ledQ.size() + vidQ.size(), 0);
    ipQ.delete();
    ledQ.delete();
    vidQ.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_oIP"}, {16'd0, bus.oIP}, 32'd0);
    check({tag, "_oLed"}, {24'd0, bus.oLed}, 32'd0);
    check({tag, "_oVideoWe"}, {31'd0, bus.oVideoWe}, 32'd0);
    check({tag, "_oVideoAddr"}, {22'd0, bus.oVideoAddr}, 32'd0);
    check({tag, "_oStackErr"}, {31'd0, bus.oStackErr}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 28'd0;
    #3;
    checkResetOutputs("por");

    // Forwarding on both source ports plus every ALU op, observed via LED
    holdReset();
    rom[0]  = sto(1, 16'd5);
    rom[1]  = sto(2, 16'd3);
    rom[2]  = ins(OP_ADD, 3, 2, 1);
    rom[3]  = ins(OP_LED, 0, 3, 0);
    rom[4]  = sto(4, 16'h0010);
    rom[5]  = ins(OP_ADD, 5, 3, 4);
    rom[6]  = ins(OP_LED, 0, 5, 0);
    rom[7]  = ins(OP_SUB, 7, 2, 5);
    rom[8]  = ins(OP_LED, 0, 7, 0);
    rom[9]  = ins(OP_SHR, 6, 7, 1);
    rom[10] = ins(OP_LED, 0, 6, 0);
    rom[11] = ins(OP_AND, 8, 7, 6);
    rom[12] = ins(OP_OR, 9, 8, 4);
    rom[13] = ins(OP_LED, 0, 9, 0);
    rom[14] = ins(OP_SHL, 10, 2, 1);
    rom[15] = ins(OP_LED, 0, 10, 0);
    pushSeq(0, 16, 1'b0);
    ledQ = '{8'h08, 8'h18, 8'hEB, 8'hFF, 8'hFB, 8'h60};
    Reset = 1'b0;
    drain("alu_drained");

    // BLE taken on equal, BLE not taken, JMP
    holdReset();
    rom[0]     = sto(1, 16'd2);
    rom[1]     = sto(2, 16'd2);
    rom[2]     = ins(OP_BLE, 8'h20, 2, 1);
    rom[8'h20] = sto(2, 16'd3);
    rom[8'h21] = ins(OP_BLE, 8'h40, 2, 1);
    rom[8'h22] = ins(OP_JMP, 8'h50, 0, 0);
    pushSeq(0, 2, 1'b0);
    pushSeq(8'h20, 8'h22, 1'b0);
    pushSeq(8'h50, 8'h52, 1'b0);
    Reset = 1'b0;
    drain("branch_drained");

    // Nested CALL/RET, then overflow on the fifth nested CALL
    holdReset();
    rom[8'h05] = ins(OP_CALL, 8'h10, 0, 0);
    rom[8'h12] = ins(OP_CALL, 8'h30, 0, 0);
    rom[8'h30] = ins(OP_RET, 0, 0, 0);
    rom[8'h13] = ins(OP_RET, 0, 0, 0);
    rom[8'h06] = ins(OP_CALL, 8'h60, 0, 0);
    rom[8'h60] = ins(OP_CALL, 8'h70, 0, 0);
    rom[8'h70] = ins(OP_CALL, 8'h80, 0, 0);
    rom[8'h80] = ins(OP_CALL, 8'h90, 0, 0);
    rom[8'h90] = ins(OP_CALL, 8'hA0, 0, 0);
    rom[8'h91] = ins(OP_RET, 0, 0, 0);
    pushSeq(0, 5, 1'b0);
    pushIp(8'h10, 1'b0); pushIp(8'h11, 1'b0); pushIp(8'h12, 1'b0);
    pushIp(8'h30, 1'b0); pushIp(8'h13, 1'b0); pushIp(8'h06, 1'b0);
    pushIp(8'h60, 1'b0); pushIp(8'h70, 1'b0); pushIp(8'h80, 1'b0);
    pushIp(8'h90, 1'b0); pushIp(8'h91, 1'b0);
    pushIp(8'h81, 1'b1); pushIp(8'h82, 1'b1); pushIp(8'h83, 1'b1);
    Reset = 1'b0;
    drain("call_drained");

    // Video write, RET on empty stack, then asynchronous reset clears outputs
    holdReset();
    rom[0] = sto(1, 16'h03FF);
    rom[1] = sto(2, 16'd6);
    rom[2] = ins(OP_WVM, 0, 2, 1);
    rom[3] = ins(OP_RET, 0, 0, 0);
    rom[4] = ins(OP_LED, 0, 2, 0);
    pushSeq(0, 4, 1'b0);
    pushSeq(5, 6, 1'b1);
    vidQ.push_back({10'h3FF, 3'b110});
    ledQ.push_back(8'h06);
    Reset = 1'b0;
    drain("video_drained");
    @(posedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    checkResetOutputs("async_reset");

    // Reset while a STO is in execute must not write the register
    holdReset();
    rom[0] = sto(5, 16'h0011);
    rom[1] = ins(OP_LED, 0, 5, 0);
    rom[3] = sto(5, 16'h0099);
    pushSeq(0, 3, 1'b0);
    ledQ.push_back(8'h11);
    Reset = 1'b0;
    repeat (4) @(posedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    checkResetOutputs("abort_reset");
    check("abort_drained", ipQ.size() + ledQ.size(), 0);
    ipQ.delete();
    ledQ.delete();
    holdReset();
    rom[0] = ins(OP_LED, 0, 5, 0);
    pushSeq(0, 2, 1'b0);
    ledQ.push_back(8'h11);
    Reset = 1'b0;
    drain("abort_no_write");

    // Op 14: MUL when enabled, otherwise a NOP leaving dest untouched
    holdReset();
    rom[0] = sto(6, 16'd8);
    rom[1] = sto(3, 16'h1234);
    rom[2] = sto(1, 16'd300);
    rom[3] = sto(2, 16'd300);
    rom[4] = ins(OP_MUL, 3, 2, 1);
    rom[5] = ins(OP_LED, 0, 3, 0);
    rom[6] = ins(OP_SHR, 4, 3, 6);
    rom[7] = ins(OP_LED, 0, 4, 0);
    pushSeq(0, 9, 1'b0);
`ifdef MINIALU_MUL_EN
    ledQ = '{8'h90, 8'h5F};
`else
    ledQ = '{8'h34, 8'h12};
`endif
    Reset = 1'b0;
    drain("mul_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
